n64_serial_poller: RTL and testbench
====================================

N64_SERIAL_POLLER -- requirements
Module: n64_serial_poller

Interface
REQ-001 Parameter US_CYCLES, 100, PCLK cycles per microsecond; all protocol timing derives from it.
REQ-002 Parameter POLL_GAP_US, 1000, idle microseconds between the end of one transaction and the start of the next.
REQ-003 Parameter RX_TIMEOUT_US, 64, maximum microseconds to wait for any expected controller falling edge.
REQ-004 PCLK  in  1  single clock; all logic on rising edge.
REQ-005 PRESERN  in  1  reset, asynchronous, active-low.
REQ-006 polling_enable  in  1  level; 1 = issue poll command 0x01 continuously.
REQ-007 controller_reset  in  1  level; a rising edge requests one reset command 0xFF.
REQ-008 n64_in  in  1  raw open-drain line level, asynchronous to PCLK.
REQ-009 n64_oe  out  1  1 = pull line low; 0 = release line (external pull-up).
REQ-010 button_data  out  32  last valid poll response, first received bit in [31].
REQ-011 data_valid  out  1  one-cycle pulse when button_data updates.
REQ-012 timeout_err  out  1  one-cycle pulse when a transaction aborts on timeout.
REQ-013 busy  out  1  high from command start until end of GAP.

Function
REQ-014 n64_in SHALL pass a 2-flop synchronizer before any use.
REQ-015 States SHALL be IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_BIT, GAP.
REQ-016 IDLE: pending reset request SHALL take priority -> send 0xFF; else polling_enable=1 -> send 0x01; else stay IDLE.
REQ-017 Reset request SHALL latch on controller_reset rising edge (previous sample resets to 0, so a level high at reset exit counts) and clear when the 0xFF command starts.
REQ-018 TX_BIT: 8 command bits MSB first, each 4 us; bit 0 = 3 us low then 1 us high, bit 1 = 1 us low then 3 us high.
REQ-019 TX_STOP: 1 us low, then release and enter RX_WAIT.
REQ-020 RX_WAIT: on synchronized falling edge, enter RX_BIT; if none within RX_TIMEOUT_US, pulse timeout_err and go GAP.
REQ-021 RX_BIT: sample 2 us after the falling edge (1 = high, 0 = low), shift in MSB first, return to RX_WAIT until the expected count is received.
REQ-022 Expected bit count: 32 for 0x01, 24 for 0xFF; the trailing controller stop bit SHALL be ignored.
REQ-023 Completed 0x01 response SHALL load button_data and pulse data_valid the cycle after the last sample; 0xFF response SHALL be discarded with no data_valid.
REQ-024 A timeout SHALL leave button_data unchanged.
REQ-025 GAP: count POLL_GAP_US with n64_oe=0, then IDLE.
REQ-026 polling_enable falling mid-transaction SHALL NOT abort it; the transaction completes and IDLE stays idle.
REQ-027 controller_reset rising mid-transaction SHALL latch and be served at the next IDLE.
REQ-028 n64_oe SHALL be 0 in every state except the low phases of TX_BIT and TX_STOP.
REQ-029 Timing counters SHALL be wide enough for POLL_GAP_US*US_CYCLES with no wrap.

Reset
REQ-030 PRESERN low SHALL asynchronously force IDLE, n64_oe=0, button_data=0, data_valid=0, timeout_err=0, busy=0, pending request=0, synchronizer=1.
REQ-031 Reset mid-transaction SHALL release the line immediately, and no partial data SHALL appear.

Configuration
REQ-032 Macro N64_GLITCH_FILTER_EN defined: a 3-sample majority filter SHALL follow the synchronizer, adding 2 cycles of input latency and rejecting 1-cycle pulses.
REQ-033 N64_GLITCH_FILTER_EN undefined: the synchronizer output SHALL feed edge detect and sampling directly.

Verification
REQ-034 Benches SHALL use US_CYCLES=4, POLL_GAP_US=10, RX_TIMEOUT_US=8.
REQ-035 polling_enable=1 with a model returning 0x80000001 -> n64_oe shows 0x01 pattern plus stop; button_data=0x80000001; one data_valid pulse; next command after 40 cycles of GAP.
REQ-036 controller_reset 0->1 while polling_enable=1 -> 0xFF sent first; 24-bit reply 0x050002 discarded; no data_valid; the following command is 0x01.
REQ-037 Silent controller -> timeout_err pulses 32 cycles after TX_STOP ends; button_data holds its prior value 0x12345678.
REQ-038 PRESERN low during bit 10 of reply -> n64_oe=0 the same cycle; all outputs 0; after release with polling_enable=1, a fresh 0x01 is sent.
REQ-039 1-cycle low glitch on idle line during RX_WAIT -> with N64_GLITCH_FILTER_EN, ignored; without it, counted as a bit (reply shifted).

Source files
------------

// File: rtl/n64_serial_poller.sv
// N64 controller serial poller: sends 0x01 polls (or 0xFF resets) on the single-wire bus and captures replies.
// Define N64_GLITCH_FILTER_EN to insert a 3-sample majority filter after the input synchronizer.
module n64_serial_poller #(
    parameter int US_CYCLES     = 100,
    parameter int POLL_GAP_US   = 1000,
    parameter int RX_TIMEOUT_US = 64
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        polling_enable,
    input  logic        controller_reset,
    input  logic        n64_in,
    output logic        n64_oe,
    output logic [31:0] button_data,
    output logic        data_valid,
    output logic        timeout_err,
    output logic        busy
);
    localparam int GAP_CYC = POLL_GAP_US * US_CYCLES;
    localparam int TO_CYC  = RX_TIMEOUT_US * US_CYCLES;
    localparam int BIT_CYC = 4 * US_CYCLES;
    localparam int TW      = $clog2(GAP_CYC + TO_CYC + BIT_CYC + 1);

    localparam logic [TW-1:0] T_US_END  = TW'(US_CYCLES - 1);
    localparam logic [TW-1:0] T_BIT_END = TW'(BIT_CYC - 1);
    localparam logic [TW-1:0] T_SAMPLE  = TW'(2 * US_CYCLES - 1);
    localparam logic [TW-1:0] T_TO_END  = TW'(TO_CYC - 1);
    localparam logic [TW-1:0] T_GAP_END = TW'(GAP_CYC - 1);
    localparam logic [TW-1:0] T_LO1     = TW'(US_CYCLES);
    localparam logic [TW-1:0] T_LO0     = TW'(3 * US_CYCLES);

    typedef enum logic [2:0] {IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_BIT, GAP} state_t;

    state_t         state, state_nxt;
    logic [TW-1:0]  tmr;
    logic [2:0]     bit_idx;
    logic [7:0]     cmd_sr;
    logic           cmd_ff;
    logic [31:0]    rx_sr;
    logic [5:0]     rx_cnt;
    logic           rst_pend;
    logic           ctrl_prev;
    logic           sync_p0, sync_p1;
    logic           line, line_prev;
    logic           fall;
    logic           rx_last;

    // Input conditioning: 2-flop synchronizer, optional majority filter
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            sync_p0   <= 1'b1;
            sync_p1   <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync_p0   <= n64_in;
            sync_p1   <= sync_p0;
            line_prev <= line;
        end
    end

`ifdef N64_GLITCH_FILTER_EN
    logic flt_p0, flt_p1, flt_q;

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            flt_p0 <= 1'b1;
            flt_p1 <= 1'b1;
            flt_q  <= 1'b1;
        end else begin
            flt_p0 <= sync_p1;
            flt_p1 <= flt_p0;
            flt_q  <= (sync_p1 & flt_p0) | (sync_p1 & flt_p1) | (flt_p0 & flt_p1);
        end
    end

    assign line = flt_q;
`else
    assign line = sync_p1;
`endif

    assign fall    = line_prev & ~line;
    assign rx_last = (rx_cnt == (cmd_ff ? 6'd23 : 6'd31));

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (rst_pend || polling_enable) state_nxt = TX_BIT;
            TX_BIT:  if (tmr == T_BIT_END && bit_idx == 3'd7) state_nxt = TX_STOP;
            TX_STOP: if (tmr == T_US_END) state_nxt = RX_WAIT;
            RX_WAIT: begin
                if (fall)                  state_nxt = RX_BIT;
                else if (tmr == T_TO_END)  state_nxt = GAP;
            end
            RX_BIT:  if (tmr == T_SAMPLE) state_nxt = rx_last ? GAP : RX_WAIT;
            GAP:     if (tmr == T_GAP_END) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        n64_oe = 1'b0;
        unique case (state)
            TX_BIT:  n64_oe = (tmr < (cmd_sr[7] ? T_LO1 : T_LO0));
            TX_STOP: n64_oe = 1'b1;
            default: n64_oe = 1'b0;
        endcase
        busy = (state != IDLE);
    end

    // Timers, shift registers, request latch and result registers
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            tmr         <= '0;
            bit_idx     <= '0;
            cmd_sr      <= '0;
            cmd_ff      <= 1'b0;
            rx_sr       <= '0;
            rx_cnt      <= '0;
            rst_pend    <= 1'b0;
            ctrl_prev   <= 1'b0;
            button_data <= '0;
            data_valid  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            timeout_err <= 1'b0;
            ctrl_prev   <= controller_reset;
            if (state_nxt != state || (state == TX_BIT && tmr == T_BIT_END))
                tmr <= '0;
            else
                tmr <= tmr + 1'b1;

            unique case (state)
                IDLE: begin
                    bit_idx <= '0;
                    rx_cnt  <= '0;
                    if (rst_pend) begin
                        cmd_sr   <= 8'hFF;
                        cmd_ff   <= 1'b1;
                        rst_pend <= 1'b0;
                    end else begin
                        cmd_sr <= 8'h01;
                        cmd_ff <= 1'b0;
                    end
                end
                TX_BIT: if (tmr == T_BIT_END) begin
                    cmd_sr  <= {cmd_sr[6:0], 1'b0};
                    bit_idx <= bit_idx + 1'b1;
                end
                RX_WAIT: if (!fall && tmr == T_TO_END) timeout_err <= 1'b1;
                RX_BIT: if (tmr == T_SAMPLE) begin
                    rx_sr  <= {rx_sr[30:0], line};
                    rx_cnt <= rx_cnt + 1'b1;
                    if (rx_last && !cmd_ff) begin
                        button_data <= {rx_sr[30:0], line};
                        data_valid  <= 1'b1;
                    end
                end
                default: ;
            endcase

            // A new request arriving while the previous one is consumed must not be lost
            if (controller_reset && !ctrl_prev) rst_pend <= 1'b1;
        end
    end
endmodule

// File: tb/tb_n64_serial_poller.sv
// Bench for n64_serial_poller: decodes the command waveform, plays a controller reply and scores the results.
module tb_n64_serial_poller;
    localparam int US     = 4;
    localparam int GAP_US = 10;
    localparam int TO_US  = 8;

    logic        PCLK = 1'b0;
    logic        PRESERN = 1'b0;
    logic        polling_enable = 1'b0;
    logic        controller_reset = 1'b0;
    logic        ctrl_pull = 1'b0;
    logic        glitch = 1'b0;
    logic        n64_in;
    logic        n64_oe;
    logic [31:0] button_data;
    logic        data_valid;
    logic        timeout_err;
    logic        busy;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          dv_cnt = 0;
    int          dv_cyc = 0;
    logic [31:0] exp_bd = '0;

    assign n64_in = ~(n64_oe | ctrl_pull | glitch);

    n64_serial_poller #(
        .US_CYCLES    (US),
        .POLL_GAP_US  (GAP_US),
        .RX_TIMEOUT_US(TO_US)
    ) dut (
        .PCLK            (PCLK),
        .PRESERN         (PRESERN),
        .polling_enable  (polling_enable),
        .controller_reset(controller_reset),
        .n64_in          (n64_in),
        .n64_oe          (n64_oe),
        .button_data     (button_data),
        .data_valid      (data_valid),
        .timeout_err     (timeout_err),
        .busy            (busy)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    always @(negedge PCLK) begin
        if (data_valid) begin
            dv_cnt <= dv_cnt + 1;
            dv_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    // Measure the low/high widths of the command waveform and rebuild the byte
    task automatic rx_cmd(output logic [7:0] cmd, output int stop_end, output bit ok);
        int lo, hi, n;
        ok = 1'b1; cmd = '0; stop_end = 0; n = 0;
        @(negedge PCLK);
        while (!n64_oe && n < 2000) begin @(negedge PCLK); n++; end
        if (!n64_oe) begin ok = 1'b0; return; end
        for (int b = 0; b < 9; b++) begin
            lo = 0; hi = 0;
            while (n64_oe && lo < 100) begin lo++; @(negedge PCLK); end
            if (b == 8) begin
                if (lo != US) ok = 1'b0;
                stop_end = cyc;
            end else begin
                while (!n64_oe && hi < 100) begin hi++; @(negedge PCLK); end
                if (lo + hi != 4 * US || (lo != US && lo != 3 * US)) ok = 1'b0;
                cmd = {cmd[6:0], (lo == US)};
            end
        end
    endtask

    task automatic send_reply(input logic [31:0] d, input int nbits, input int abort_bit);
        logic bv;
        for (int b = 0; b < nbits; b++) begin
            bv = d[nbits - 1 - b];
            ctrl_pull = 1'b1;
            if (b == abort_bit) begin
                wait_cyc(2);
                PRESERN = 1'b0;
                #1;
                chk("rst_oe", 32'(n64_oe), 32'd0);
                chk("rst_data", button_data, 32'd0);
                chk("rst_dv", 32'(data_valid), 32'd0);
                chk("rst_to", 32'(timeout_err), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                ctrl_pull = 1'b0;
                return;
            end
            wait_cyc(bv ? US : 3 * US);
            ctrl_pull = 1'b0;
            wait_cyc(bv ? 3 * US : US);
        end
        ctrl_pull = 1'b1;
        wait_cyc(US);
        ctrl_pull = 1'b0;
    endtask

    // mode: 0 plain, 1 glitch before reply, 2 drop polling_enable, 3 raise controller_reset
    task automatic xact(input logic [7:0] exp_cmd, input logic [31:0] d, input int nbits,
                        input int mode, input logic [31:0] exp_data, input bit exp_dv);
        logic [7:0] cmd;
        int stop_end, dv0, n, busy_low;
        bit ok;
        rx_cmd(cmd, stop_end, ok);
        chk("cmd_shape", 32'(ok), 32'd1);
        chk("cmd_code", 32'(cmd), 32'(exp_cmd));
        dv0 = dv_cnt;
        if (mode == 2) polling_enable = 1'b0;
        if (mode == 3) controller_reset = 1'b1;
        if (mode == 1) begin
            wait_cyc(1); glitch = 1'b1; wait_cyc(1); glitch = 1'b0; wait_cyc(18);
        end else begin
            wait_cyc(4 + int'($urandom_range(0, 8)));
        end
        send_reply(d, nbits, -1);
        n = 0;
        while (busy && n < 500) begin @(negedge PCLK); n++; end
        busy_low = cyc;
        chk("busy_end", 32'(busy), 32'd0);
        chk("dv_pulses", 32'(dv_cnt - dv0), 32'(exp_dv));
        if (exp_dv) begin
            exp_bd = exp_data;
            chk("gap_len", 32'(busy_low - dv_cyc), 32'(GAP_US * US));
        end
        chk("button_data", button_data, exp_bd);
    endtask

    initial begin
        logic [7:0]  cmd;
        logic [31:0] d, g_exp;
        int          se, n, to_at, oe_hi;
        bit          ok;

        wait_cyc(3);
        chk("reset_oe", 32'(n64_oe), 32'd0);
        chk("reset_data", button_data, 32'd0);
        chk("reset_dv", 32'(data_valid), 32'd0);
        chk("reset_to", 32'(timeout_err), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        PRESERN = 1'b1;
        wait_cyc(20);
        chk("idle_no_enable", 32'(busy), 32'd0);

        polling_enable = 1'b1;
        xact(8'h01, 32'h80000001, 32, 0, 32'h80000001, 1'b1);
        for (int i = 0; i < 3; i++) begin
            d = $urandom();
            xact(8'h01, d, 32, 0, d, 1'b1);
        end

        // Enable drops mid-transaction: it completes, then the bus stays quiet
        d = $urandom();
        xact(8'h01, d, 32, 2, d, 1'b1);
        oe_hi = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge PCLK);
            if (n64_oe || busy) oe_hi++;
        end
        chk("idle_after_drop", 32'(oe_hi), 32'd0);
        polling_enable = 1'b1;

        // Reset request raised mid-poll is served next with 0xFF, reply discarded
        d = $urandom();
        xact(8'h01, d, 32, 3, d, 1'b1);
        xact(8'hFF, 32'h00050002, 24, 0, 32'h0, 1'b0);
        controller_reset = 1'b0;
        xact(8'h01, 32'h12345678, 32, 0, 32'h12345678, 1'b1);

        // Silent controller
        rx_cmd(cmd, se, ok);
        chk("to_cmd", 32'(cmd), 32'h01);
        n = 0;
        while (!timeout_err && n < 200) begin @(negedge PCLK); n++; end
        to_at = cyc;
        chk("to_seen", 32'(timeout_err), 32'd1);
        chk("to_delay", 32'(to_at - se), 32'(TO_US * US));
        @(negedge PCLK);
        chk("to_one_cycle", 32'(timeout_err), 32'd0);
        chk("to_data_held", button_data, 32'h12345678);
        n = 0;
        while (busy && n < 500) begin @(negedge PCLK); n++; end

        // One-cycle low glitch while waiting for the reply
        d = $urandom();
`ifdef N64_GLITCH_FILTER_EN
        g_exp = d;
`else
        g_exp = {1'b1, d[31:1]};
`endif
        xact(8'h01, d, 32, 1, g_exp, 1'b1);

        // Reset during reply bit 10, then during a command low phase
        rx_cmd(cmd, se, ok);
        chk("pre_rst_cmd", 32'(cmd), 32'h01);
        wait_cyc(6);
        send_reply($urandom(), 32, 10);
        exp_bd = '0;
        wait_cyc(3);
        PRESERN = 1'b1;
        n = 0;
        @(negedge PCLK);
        while (!n64_oe && n < 500) begin @(negedge PCLK); n++; end
        #2 PRESERN = 1'b0;
        #1 chk("oe_async_rst", 32'(n64_oe), 32'd0);
        wait_cyc(2);
        PRESERN = 1'b1;
        d = $urandom();
        xact(8'h01, d, 32, 0, d, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
